// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter for the shared register-file write port, with a
// pending-write scoreboard that stalls decode on RAW/WAW hazards.
module rf_wb_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                issue_valid,
    input  logic [ADDR_W-1:0]   issue_rd,
    input  logic [ADDR_W-1:0]   issue_rs1,
    input  logic [ADDR_W-1:0]   issue_rs2,
    output logic                stall,
    input  logic                req0_valid,
    input  logic [ADDR_W-1:0]   req0_addr,
    input  logic [DATA_W-1:0]   req0_data,
    output logic                req0_ready,
    input  logic                req1_valid,
    input  logic [ADDR_W-1:0]   req1_addr,
    input  logic [DATA_W-1:0]   req1_data,
    output logic                req1_ready,
    output logic                wb_en,
    output logic [ADDR_W-1:0]   wb_addr,
    output logic [DATA_W-1:0]   wb_data,
    output logic [NUM_REGS-1:0] busy_mask
);

    if (NUM_REGS != (1 << ADDR_W)) begin : g_bad_num_regs
        $error("rf_wb_arbiter: NUM_REGS must equal 2**ADDR_W");
    end

    logic                last_grant;   // 1 = requester 1 won most recently
    logic                grant_any;
    logic [ADDR_W-1:0]   grant_addr;
    logic [DATA_W-1:0]   grant_data;
    logic                issue_accept;
    logic [NUM_REGS-1:0] busy_next;

    // Round-robin: on contention the requester that did not win last time goes.
    assign req0_ready = req0_valid & (~req1_valid | last_grant);
    assign req1_ready = req1_valid & (~req0_valid | ~last_grant);
    assign grant_any  = req0_ready | req1_ready;
    assign grant_addr = req1_ready ? req1_addr : req0_addr;
    assign grant_data = req1_ready ? req1_data : req0_data;

    // r0 never has a pending write, so it never causes a hazard.
    assign stall = issue_valid & ((busy_mask[issue_rs1] & (issue_rs1 != '0)) |
                                  (busy_mask[issue_rs2] & (issue_rs2 != '0)) |
                                  (busy_mask[issue_rd]  & (issue_rd  != '0)));
    assign issue_accept = issue_valid & ~stall;

    // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        busy_next = busy_mask;
        if (grant_any) begin
            busy_next[grant_addr] = 1'b0;
        end
        // Applied after the clear so a same-edge issue to the granted register stays pending.
        if (issue_accept) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
            wb_en      <= 1'b0;
            wb_addr    <= '0;
            wb_data    <= '0;
            busy_mask  <= '0;
        end else begin
            busy_mask <= busy_next;
            wb_en     <= grant_any & (grant_addr != '0);
            if (grant_any) begin
                last_grant <= req1_ready;
                wb_addr    <= grant_addr;
                wb_data    <= grant_data;
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: grants push expected write-port values,
// the cycle after each edge pops and compares them.
module tb_rf_wb_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          issue_valid;
    logic [AW-1:0] issue_rd, issue_rs1, issue_rs2;
    logic          stall;
    logic          req0_valid, req1_valid;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [DW-1:0] req0_data, req1_data;
    logic          req0_ready, req1_ready;
    logic          wb_en;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic [NR-1:0] busy_mask;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR)) dut (
        .clk        (clk),
        .reset      (reset),
        .issue_valid(issue_valid),
        .issue_rd   (issue_rd),
        .issue_rs1  (issue_rs1),
        .issue_rs2  (issue_rs2),
        .stall      (stall),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .busy_mask  (busy_mask)
    );

    typedef struct packed {
        logic          en;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wb_t;

    wb_t           exp_q[$];
    int            errors = 0;
    int            checks = 0;
    logic          model_last;
    logic [NR-1:0] model_busy;
    logic [AW-1:0] model_addr;
    logic [DW-1:0] model_data;

    task automatic model_reset();
        model_last = 1'b1;
        model_busy = '0;
        model_addr = '0;
        model_data = '0;
        exp_q.delete();
    endtask

    task automatic set_idle();
        issue_valid = 1'b0; issue_rd = '0; issue_rs1 = '0; issue_rs2 = '0;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    endtask

    task automatic set_issue(input logic [AW-1:0] rd, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
        issue_valid = 1'b1; issue_rd = rd; issue_rs1 = rs1; issue_rs2 = rs2;
    endtask

    // Called shortly after a rising edge with inputs already driven; returns at posedge+1.
    task automatic step(input string tag);
        logic g0, g1, m_stall, exp_en;
        wb_t  e;
        #4;
        g0 = req0_valid & (~req1_valid | model_last);
        g1 = req1_valid & (~req0_valid | ~model_last);
        m_stall = issue_valid & ((model_busy[issue_rs1] & (issue_rs1 != 0)) |
                                 (model_busy[issue_rs2] & (issue_rs2 != 0)) |
                                 (model_busy[issue_rd]  & (issue_rd  != 0)));
        checks++;
        if (req0_ready !== g0) begin
            errors++; $display("FAIL %s req0_ready: got %b expected %b", tag, req0_ready, g0);
        end
        checks++;
        if (req1_ready !== g1) begin
            errors++; $display("FAIL %s req1_ready: got %b expected %b", tag, req1_ready, g1);
        end
        checks++;
        if (stall !== m_stall) begin
            errors++; $display("FAIL %s stall: got %b expected %b", tag, stall, m_stall);
        end
        if (g0) begin
            exp_q.push_back('{en: (req0_addr != 0), addr: req0_addr, data: req0_data});
            model_busy[req0_addr] = 1'b0;
            model_last = 1'b0;
        end else if (g1) begin
            exp_q.push_back('{en: (req1_addr != 0), addr: req1_addr, data: req1_data});
            model_busy[req1_addr] = 1'b0;
            model_last = 1'b1;
        end
        if (issue_valid && !m_stall) model_busy[issue_rd] = 1'b1;
        model_busy[0] = 1'b0;
        @(posedge clk);
        #1;
        exp_en = 1'b0;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            exp_en = e.en; model_addr = e.addr; model_data = e.data;
        end
        checks++;
        if (wb_en !== exp_en) begin
            errors++; $display("FAIL %s wb_en: got %b expected %b", tag, wb_en, exp_en);
        end
        checks++;
        if (wb_addr !== model_addr) begin
            errors++; $display("FAIL %s wb_addr: got %0d expected %0d", tag, wb_addr, model_addr);
        end
        checks++;
        if (wb_data !== model_data) begin
            errors++; $display("FAIL %s wb_data: got %h expected %h", tag, wb_data, model_data);
        end
        checks++;
        if (busy_mask !== model_busy) begin
            errors++; $display("FAIL %s busy_mask: got %h expected %h", tag, busy_mask, model_busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_idle();
        model_reset();
        #2;
        checks++;
        if ({wb_en, wb_addr, wb_data, busy_mask} !== '0) begin
            errors++; $display("FAIL reset outputs: got en=%b addr=%0d data=%h busy=%h expected all zero",
                               wb_en, wb_addr, wb_data, busy_mask);
        end
        checks++;
        if ({req0_ready, req1_ready, stall} !== 3'b000) begin
            errors++; $display("FAIL reset comb: got r0=%b r1=%b stall=%b expected 000", req0_ready, req1_ready, stall);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'h1234;
        step("single_grant");
        checks++;
        if (wb_en !== 1'b1 || wb_addr !== 5'd5 || wb_data !== 32'h1234) begin
            errors++; $display("FAIL single_wb: got en=%b addr=%0d data=%h expected 1/5/1234", wb_en, wb_addr, wb_data);
        end
        set_idle();
        step("single_drain");
    endtask

    task automatic test_contention();
        req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'hA4;
        step("cont_warmup");
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'hC3;
        for (int i = 0; i < 4; i++) begin
            step($sformatf("cont_%0d", i));
            checks++;
            if (wb_en !== 1'b1 || wb_addr !== ((i % 2 == 0) ? 5'd3 : 5'd4)) begin
                errors++; $display("FAIL cont_order_%0d: got en=%b addr=%0d expected en=1 addr=%0d",
                                   i, wb_en, wb_addr, (i % 2 == 0) ? 3 : 4);
            end
        end
        set_idle();
        step("cont_drain");
    endtask

    task automatic test_raw();
        set_issue(5'd7, 5'd1, 5'd2);
        step("raw_issue_rd7");
        set_issue(5'd0, 5'd7, 5'd0);
        step("raw_stall_a");
        step("raw_stall_b");
        req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'hBEEF;
        step("raw_grant");
        req1_valid = 1'b0;
        #2;
        checks++;
        if (stall !== 1'b0 || wb_en !== 1'b1 || wb_addr !== 5'd7 || wb_data !== 32'hBEEF) begin
            errors++; $display("FAIL raw_release: got stall=%b en=%b addr=%0d data=%h expected 0/1/7/beef",
                               stall, wb_en, wb_addr, wb_data);
        end
        step("raw_accept");
        set_idle();
        step("raw_drain");
    endtask

    task automatic test_r0();
        set_issue(5'd0, 5'd0, 5'd0);
        step("r0_issue");
        set_idle();
        req0_valid = 1'b1; req0_addr = 5'd0; req0_data = 32'hFFFF;
        step("r0_grant");
        set_idle();
        step("r0_drain");
        checks++;
        if (busy_mask !== '0) begin
            errors++; $display("FAIL r0_busy: got %h expected 0", busy_mask);
        end
    endtask

    task automatic test_same_edge();
        set_issue(5'd9, 5'd0, 5'd0);
        req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h55;
        step("same_edge");
        checks++;
        if (busy_mask[9] !== 1'b1) begin
            errors++; $display("FAIL same_edge_set_wins: got busy[9]=%b expected 1", busy_mask[9]);
        end
        set_idle();
        req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 32'h99;
        step("same_edge_clear");
        set_idle();
        step("same_edge_drain");
    endtask

    task automatic test_async_reset();
        set_issue(5'd7, 5'd0, 5'd0);
        step("ar_issue7");
        set_issue(5'd10, 5'd0, 5'd0);
        step("ar_issue10");
        set_idle();
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'h77;
        step("ar_grant");
        set_idle();
        checks++;
        if (busy_mask !== 32'h0000_0480 || wb_en !== 1'b1) begin
            errors++; $display("FAIL ar_pre: got busy=%h en=%b expected 00000480/1", busy_mask, wb_en);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (busy_mask !== '0 || wb_en !== 1'b0 || wb_addr !== '0 || wb_data !== '0) begin
            errors++; $display("FAIL ar_immediate: got busy=%h en=%b addr=%0d data=%h expected all zero",
                               busy_mask, wb_en, wb_addr, wb_data);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h33;
        req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h44;
        #2;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++; $display("FAIL ar_first_grant: got r0=%b r1=%b expected 1/0", req0_ready, req1_ready);
        end
        step("ar_contest");
        set_idle();
        step("ar_drain");
        step("ar_idle");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_raw();
        test_r0();
        test_same_edge();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
